// File: rtl/freq_collector_pkg.sv
// freq_collector_pkg: shared huffman constants, frame layout and FSM encodings
package freq_collector_pkg;

    localparam int SYM_W       = 8;
    localparam int NODE_NUM_W  = 9;
    localparam int WEIGHT_W    = 27;
    localparam int FRAME_W     = 36;
    localparam int NUM_SYM     = 256;

    localparam int FRM_NUM_MSB = 35;
    localparam int FRM_NUM_LSB = 27;
    localparam int FRM_WT_MSB  = 26;
    localparam int FRM_WT_LSB  = 0;
    localparam int FRM_WT_W    = FRM_WT_MSB - FRM_WT_LSB + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef logic [FRAME_W-1:0] frame_t;

    function automatic frame_t make_frame(input logic [NODE_NUM_W-1:0] num, input logic [FRM_WT_W-1:0] wt);
        frame_t f;
        f = '0;
        f[FRM_NUM_MSB:FRM_NUM_LSB] = num;
        f[FRM_WT_MSB:FRM_WT_LSB]   = wt;
        return f;
    endfunction

endpackage

// File: rtl/freq_collector_bank.sv
// freq_bin_bank: per-symbol saturating counters with read port and clear-on-read
module freq_bin_bank
    import freq_collector_pkg::*;
#(
    parameter int NUM_SYM  = freq_collector_pkg::NUM_SYM,
    parameter int WEIGHT_W = freq_collector_pkg::WEIGHT_W
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  i_inc,
    input  logic [SYM_W-1:0]      i_inc_sym,
    input  logic                  i_clr,
    input  logic [NODE_NUM_W-1:0] i_rd_idx,
    output logic [WEIGHT_W-1:0]   o_rd_weight
);

    localparam int IDX_W = NUM_SYM > 1 ? $clog2(NUM_SYM) : 1;

    logic [WEIGHT_W-1:0] r_bin [NUM_SYM];
    logic [IDX_W-1:0]    w_inc_idx;
    logic [IDX_W-1:0]    w_rd_idx;
    logic                w_inc_hit;
    logic                w_rd_hit;

    assign w_inc_idx   = i_inc_sym[IDX_W-1:0];
    assign w_rd_idx    = i_rd_idx[IDX_W-1:0];
    assign w_inc_hit   = 32'(i_inc_sym) < NUM_SYM;
    assign w_rd_hit    = 32'(i_rd_idx) < NUM_SYM;
    assign o_rd_weight = w_rd_hit ? r_bin[w_rd_idx] : '0;

    // count accepted symbols (sticking at all-ones) and zero a bin as it is read out
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_SYM; i++) r_bin[i] <= '0;
        end else begin
            if (i_inc && w_inc_hit && r_bin[w_inc_idx] != '1) r_bin[w_inc_idx] <= r_bin[w_inc_idx] + WEIGHT_W'(1);
            if (i_clr && w_rd_hit) r_bin[w_rd_idx] <= '0;
        end
    end

endmodule

// File: rtl/freq_collector.sv
// freq_collector: histogram a byte block, then burst one node frame per symbol
module freq_collector
    import freq_collector_pkg::*;
#(
    parameter int NUM_SYM  = freq_collector_pkg::NUM_SYM,
    parameter int WEIGHT_W = freq_collector_pkg::WEIGHT_W
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [SYM_W-1:0]   i_sym_in,
    input  logic               i_sym_valid,
    input  logic               i_sym_last,
    output logic               o_sym_ready,
    input  logic               i_net_ready,
    output logic [FRAME_W-1:0] o_frame_out,
    output logic               o_frame_wr,
    output logic               o_blk_done
);

    localparam logic [NODE_NUM_W-1:0] END_IDX = NODE_NUM_W'(NUM_SYM);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [NODE_NUM_W-1:0] r_idx;
    logic [FRAME_W-1:0]    r_frame_out;
    logic                  r_frame_wr;
    logic [WEIGHT_W-1:0]   w_weight;
    logic                  w_accept;
    logic                  w_fire;
    logic                  w_all_sent;

    assign o_sym_ready = rstN && (r_state == S_IDLE || r_state == S_COUNT);
    assign w_accept    = i_sym_valid && o_sym_ready;
    assign w_all_sent  = r_idx == END_IDX;
    assign w_fire      = (r_state == S_WAIT && i_net_ready) || (r_state == S_EMIT && !w_all_sent);
    assign o_blk_done  = r_state == S_DONE;
    assign o_frame_out = r_frame_out;
    assign o_frame_wr  = r_frame_wr;

    freq_bin_bank #(
        .NUM_SYM  (NUM_SYM),
        .WEIGHT_W (WEIGHT_W)
    ) u_bank (
        .clk         (clk),
        .rstN        (rstN),
        .i_inc       (w_accept),
        .i_inc_sym   (i_sym_in),
        .i_clr       (w_fire),
        .i_rd_idx    (r_idx),
        .o_rd_weight (w_weight)
    );

    // block sequencing: collect, hold for the sorter, burst, pulse done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = i_sym_last ? S_WAIT : S_COUNT;
            S_COUNT: if (w_accept && i_sym_last) w_state_nxt = S_WAIT;
            S_WAIT:  if (i_net_ready) w_state_nxt = S_EMIT;
            S_EMIT:  if (w_all_sent) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end

    // emit index advances once per frame, the first one fired on leaving WAIT
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_idx <= '0;
        else if (w_fire) r_idx <= r_idx + NODE_NUM_W'(1);
        else if (r_state == S_DONE) r_idx <= '0;
    end

    // registered frame output, forced to zero between frames
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_frame_wr  <= 1'b0;
            r_frame_out <= '0;
        end else begin
            r_frame_wr  <= w_fire;
            r_frame_out <= w_fire ? make_frame(r_idx, FRM_WT_W'(w_weight)) : '0;
        end
    end

endmodule

// File: tb/tb_freq_collector.sv
// tb_freq_collector: directed checks of counting, emit burst, handshake and reset
module tb_freq_collector;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [7:0]  sym = '0;
    logic        sv = 1'b0;
    logic        sl = 1'b0;
    logic        nr = 1'b1;
    logic        sym_ready;
    logic [35:0] frame;
    logic        fwr;
    logic        done;

    logic [7:0]  s_sym = '0;
    logic        s_sv = 1'b0;
    logic        s_sl = 1'b0;
    logic        s_nr = 1'b1;
    logic        s_ready;
    logic [35:0] s_frame;
    logic        s_fwr;
    logic        s_done;

    int          checks = 0;
    int          failures = 0;
    logic [8:0]  got_num [256];
    logic [26:0] got_wt [256];
    logic [26:0] e_wt [256];
    int          got_n;
    int          got_lat;
    logic        got_done;
    logic        got_done2;
    logic        got_zero_ok;

    always #5 clk = ~clk;

    freq_collector dut (
        .clk         (clk),
        .rstN        (rstN),
        .i_sym_in    (sym),
        .i_sym_valid (sv),
        .i_sym_last  (sl),
        .o_sym_ready (sym_ready),
        .i_net_ready (nr),
        .o_frame_out (frame),
        .o_frame_wr  (fwr),
        .o_blk_done  (done)
    );

    freq_collector #(.NUM_SYM(4), .WEIGHT_W(3)) dut_s (
        .clk         (clk),
        .rstN        (rstN),
        .i_sym_in    (s_sym),
        .i_sym_valid (s_sv),
        .i_sym_last  (s_sl),
        .o_sym_ready (s_ready),
        .i_net_ready (s_nr),
        .o_frame_out (s_frame),
        .o_frame_wr  (s_fwr),
        .o_blk_done  (s_done)
    );

    task automatic drive_sym(input logic [7:0] s, input logic l);
        sym = s;
        sv = 1'b1;
        sl = l;
        @(negedge clk);
        sv = 1'b0;
        sl = 1'b0;
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 256; k++) e_wt[k] = '0;
    endtask

    task automatic capture(input int budget);
        for (int k = 0; k < 256; k++) begin
            got_num[k] = 'x;
            got_wt[k] = 'x;
        end
        got_lat = 0;
        got_n = 0;
        got_zero_ok = 1'b1;
        while (!fwr && got_lat < budget) begin
            if (frame !== 36'd0) got_zero_ok = 1'b0;
            @(negedge clk);
            got_lat++;
        end
        while (fwr && got_n < 264) begin
            if (got_n < 256) begin
                got_num[got_n] = frame[35:27];
                got_wt[got_n] = frame[26:0];
            end
            got_n++;
            @(negedge clk);
        end
        got_done = done;
        @(negedge clk);
        got_done2 = done;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sym_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", sym_ready); end
        checks++;
        if (fwr !== 1'b0 || frame !== 36'd0) begin failures++; $display("FAIL reset_frame got wr=%b frame=%h want 0/0", fwr, frame); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (s_ready !== 1'b0 || s_fwr !== 1'b0) begin failures++; $display("FAIL reset_small got rdy=%b wr=%b want 0/0", s_ready, s_fwr); end
        rstN = 1'b1;
        @(negedge clk);
        checks++;
        if (sym_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got %b want 1", sym_ready); end
    endtask

    task automatic test_basic();
        clear_exp();
        e_wt[8'h41] = 27'd3;
        e_wt[8'h42] = 27'd1;
        nr = 1'b1;
        drive_sym(8'h41, 1'b0);
        drive_sym(8'h41, 1'b0);
        drive_sym(8'h41, 1'b0);
        drive_sym(8'h42, 1'b1);
        capture(20);
        checks++;
        if (got_lat !== 1) begin failures++; $display("FAIL basic_latency got %0d want 1", got_lat); end
        checks++;
        if (got_n !== 256) begin failures++; $display("FAIL basic_count got %0d want 256", got_n); end
        checks++;
        if (!got_zero_ok) begin failures++; $display("FAIL basic_idle_zero got nonzero frame_out want 0"); end
        checks++;
        if (got_done !== 1'b1 || got_done2 !== 1'b0) begin failures++; $display("FAIL basic_done got %b%b want 10", got_done, got_done2); end
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (got_num[k] !== 9'(k) || got_wt[k] !== e_wt[k]) begin
                failures++;
                $display("FAIL basic_frame%0d got %h/%h want %h/%h", k, got_num[k], got_wt[k], 9'(k), e_wt[k]);
            end
        end
    endtask

    task automatic test_single_ff();
        clear_exp();
        e_wt[255] = 27'd1;
        drive_sym(8'hFF, 1'b1);
        capture(20);
        checks++;
        if (got_n !== 256 || got_done !== 1'b1) begin failures++; $display("FAIL ff_count got %0d done=%b want 256 done=1", got_n, got_done); end
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (got_num[k] !== 9'(k) || got_wt[k] !== e_wt[k]) begin
                failures++;
                $display("FAIL ff_frame%0d got %h/%h want %h/%h", k, got_num[k], got_wt[k], 9'(k), e_wt[k]);
            end
        end
    endtask

    task automatic test_wait();
        logic hold_ok;
        clear_exp();
        e_wt[8'h20] = 27'd1;
        nr = 1'b0;
        drive_sym(8'h20, 1'b1);
        hold_ok = 1'b1;
        sym = 8'h10;
        sv = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sym_ready !== 1'b0 || fwr !== 1'b0 || frame !== 36'd0) hold_ok = 1'b0;
            @(negedge clk);
        end
        sv = 1'b0;
        checks++;
        if (!hold_ok) begin failures++; $display("FAIL wait_hold got activity while net_ready low want ready=0 wr=0"); end
        nr = 1'b1;
        capture(20);
        checks++;
        if (got_lat !== 1) begin failures++; $display("FAIL wait_latency got %0d want 1", got_lat); end
        checks++;
        if (got_n !== 256) begin failures++; $display("FAIL wait_count got %0d want 256", got_n); end
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (got_num[k] !== 9'(k) || got_wt[k] !== e_wt[k]) begin
                failures++;
                $display("FAIL wait_frame%0d got %h/%h want %h/%h", k, got_num[k], got_wt[k], 9'(k), e_wt[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive_sym(8'h05, 1'b0);
        drive_sym(8'h05, 1'b1);
        capture(20);
        checks++;
        if (got_wt[5] !== 27'd2) begin failures++; $display("FAIL b2b_first got %h want 2", got_wt[5]); end
        clear_exp();
        e_wt[5] = 27'd1;
        e_wt[6] = 27'd1;
        drive_sym(8'h05, 1'b0);
        drive_sym(8'h06, 1'b1);
        capture(20);
        checks++;
        if (got_n !== 256 || got_done !== 1'b1) begin failures++; $display("FAIL b2b_count got %0d done=%b want 256 done=1", got_n, got_done); end
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (got_num[k] !== 9'(k) || got_wt[k] !== e_wt[k]) begin
                failures++;
                $display("FAIL b2b_frame%0d got %h/%h want %h/%h", k, got_num[k], got_wt[k], 9'(k), e_wt[k]);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        drive_sym(8'h09, 1'b0);
        drive_sym(8'h09, 1'b0);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        clear_exp();
        e_wt[8'h0A] = 27'd1;
        drive_sym(8'h0A, 1'b1);
        capture(20);
        checks++;
        if (got_n !== 256) begin failures++; $display("FAIL midcount_count got %0d want 256", got_n); end
        checks++;
        if (got_wt[9] !== 27'd0 || got_wt[10] !== 27'd1) begin
            failures++;
            $display("FAIL midcount_bins got 09=%h 0a=%h want 0/1", got_wt[9], got_wt[10]);
        end
    endtask

    task automatic test_reset_mid_emit();
        int w;
        logic quiet;
        drive_sym(8'h33, 1'b1);
        w = 0;
        while (!(fwr === 1'b1 && frame[35:27] === 9'd100) && w < 400) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 400) begin failures++; $display("FAIL midemit_reach got timeout want frame 100"); end
        rstN = 1'b0;
        #1;
        checks++;
        if (fwr !== 1'b0 || frame !== 36'd0) begin failures++; $display("FAIL midemit_abort got wr=%b frame=%h want 0/0", fwr, frame); end
        @(negedge clk);
        rstN = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (fwr !== 1'b0 || done !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!quiet) begin failures++; $display("FAIL midemit_quiet got frame activity after reset want none"); end
        clear_exp();
        e_wt[8'h07] = 27'd1;
        drive_sym(8'h07, 1'b1);
        capture(20);
        checks++;
        if (got_n !== 256) begin failures++; $display("FAIL midemit_count got %0d want 256", got_n); end
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (got_num[k] !== 9'(k) || got_wt[k] !== e_wt[k]) begin
                failures++;
                $display("FAIL midemit_frame%0d got %h/%h want %h/%h", k, got_num[k], got_wt[k], 9'(k), e_wt[k]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [35:0] want [4];
        logic [35:0] got [4];
        int w;
        int n;
        want[0] = {9'd0, 27'd7};
        want[1] = {9'd1, 27'd1};
        want[2] = {9'd2, 27'd0};
        want[3] = {9'd3, 27'd0};
        s_sym = 8'd1;
        s_sv = 1'b1;
        @(negedge clk);
        s_sym = 8'd0;
        for (int i = 0; i < 9; i++) begin
            s_sl = (i == 8);
            @(negedge clk);
        end
        s_sv = 1'b0;
        s_sl = 1'b0;
        w = 0;
        while (!s_fwr && w < 20) begin
            @(negedge clk);
            w++;
        end
        n = 0;
        for (int k = 0; k < 4; k++) got[k] = 'x;
        while (s_fwr && n < 8) begin
            if (n < 4) got[n] = s_frame;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 4 || s_done !== 1'b1) begin failures++; $display("FAIL sat_count got %0d done=%b want 4 done=1", n, s_done); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== want[k]) begin failures++; $display("FAIL sat_frame%0d got %h want %h", k, got[k], want[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_ff();
        test_wait();
        test_back_to_back();
        test_reset_mid_count();
        test_reset_mid_emit();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_collector.md
FREQ_COLLECTOR -- requirements
Module: freq_collector

Interface
REQ-001 Parameter NUM_SYM, default 256, number of symbol bins; also the number of frames emitted per block.
REQ-002 Parameter WEIGHT_W, default 27, counter/weight width in bits.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rstN  input  1  reset; asynchronous, active-low.
REQ-005 sym_in  input  8  literal byte to be counted.
REQ-006 sym_valid  input  1  sym_in valid this cycle.
REQ-007 sym_last  input  1  qualified by sym_valid; marks the final symbol of the block.
REQ-008 sym_ready  output  1  high when symbols are accepted.
REQ-009 net_ready  input  1  high when the downstream sorter is idle and may accept a new frame burst.
REQ-010 frame_out  output  36  node frame: [35:27] node number (9 bit), [26:0] weight.
REQ-011 frame_wr  output  1  frame_out valid; asserted on consecutive cycles.
REQ-012 blk_done  output  1  one-cycle pulse after the last frame of a block.

Function
REQ-013 The block SHALL implement states IDLE, COUNT, WAIT, EMIT and DONE.
REQ-014 IDLE SHALL go to COUNT on the first accepted symbol, or to WAIT if that symbol also has sym_last.
REQ-015 A symbol is accepted when sym_valid and sym_ready are both high; sym_ready SHALL be high in IDLE and COUNT only.
REQ-016 An accepted symbol SHALL increment bin[sym_in] by 1, visible to the next cycle, so back-to-back identical symbols all count.
REQ-017 A bin SHALL saturate at 2^WEIGHT_W-1 and never wrap.
REQ-018 An accepted symbol with sym_last high SHALL be counted and SHALL move the FSM to WAIT.
REQ-019 WAIT SHALL go to EMIT on the first cycle net_ready is high.
REQ-020 EMIT SHALL assert frame_wr for exactly NUM_SYM consecutive cycles, with no gaps.
REQ-021 Frame k (k = 0..NUM_SYM-1) SHALL carry node number k, zero-extended to 9 bit, in strictly increasing order.
REQ-022 Frame k SHALL carry weight bin[k]; zero-weight bins SHALL still be emitted.
REQ-023 Each bin SHALL be cleared to 0 in the same cycle its frame is emitted.
REQ-024 After frame NUM_SYM-1 the FSM SHALL enter DONE.
REQ-025 DONE SHALL assert blk_done for one cycle, then return to IDLE.
REQ-026 frame_out SHALL be 0 whenever frame_wr is low.
REQ-027 sym_valid outside IDLE/COUNT SHALL be ignored; bins SHALL be unchanged.
REQ-028 net_ready falling during EMIT SHALL NOT pause the burst.
REQ-029 Latency: the first frame_wr SHALL occur 1 cycle after WAIT is entered with net_ready high, or the cycle after net_ready rises.

Reset
REQ-030 While rstN is low: all bins 0, FSM in IDLE, emit index 0, frame_out 0, frame_wr 0, blk_done 0.
REQ-031 While rstN is low, sym_ready SHALL be 0.
REQ-032 Reset mid-COUNT or mid-EMIT SHALL discard the partial block; after release, no frame_wr until a new block completes.

Structure
REQ-033 A shared huffman package SHALL hold: SYM_W=8, NODE_NUM_W=9, WEIGHT_W=27, FRAME_W=36, NUM_SYM=256.
REQ-034 The package SHALL hold the frame field positions: number [35:27], weight [26:0].
REQ-035 The bin array with its saturating increment and clear-on-emit SHALL be one sub-module, freq_bin_bank.
REQ-036 The FSM, emit counter and output register SHALL stay in freq_collector.

Verification
REQ-037 Symbols 0x41,0x41,0x41,0x42 (last on 0x42), net_ready=1 -> 256 contiguous frame_wr; frame 0x41 = {9'h041, 27'd3}; frame 0x42 = {9'h042, 27'd1}; all other frames weight 0; blk_done one cycle after frame 255.
REQ-038 Single symbol 0xFF with sym_last -> frame 255 weight 1; frames 0..254 weight 0.
REQ-039 net_ready held low 20 cycles after last -> sym_ready=0, frame_wr=0 throughout; burst starts 1 cycle after net_ready rises.
REQ-040 Two back-to-back blocks -> second block's weights exclude the first block's counts (clear-on-emit checked).
REQ-041 Force bin 0x00 to 2^27-2, then feed 3 symbols 0x00 -> weight 27'h7FFFFFF.
REQ-042 rstN pulsed low at frame 100 of EMIT -> frame_wr=0 immediately; after a new one-symbol block, only that symbol's bin is nonzero.
